// File: rtl/fft_sdf_stage_ctrl_if.sv
// Handshake and status bundle between an SDF stage sequencer and its datapath/driver.
// The slave modport is the sequencer's view; the master modport drives beats and flush.
interface fft_sdf_stage_ctrl_if #(
    parameter int unsigned HALF_BEATS = 16,
    parameter int unsigned FCNT_W     = 16
);
    localparam int unsigned IdxW = $clog2(HALF_BEATS);

    logic              din_valid;
    logic              flush;
    logic              bfly_valid;
    logic              shift_sel;
    logic              twd_valid;
    logic [IdxW-1:0]   twd_idx;
    logic              out_valid;
    logic              out_sop;
    logic              out_eop;
    logic [FCNT_W-1:0] frame_cnt;
    logic              busy;

    modport master (
        output din_valid, flush,
        input  bfly_valid, shift_sel, twd_valid, twd_idx, out_valid, out_sop, out_eop,
        input  frame_cnt, busy
    );

    modport slave (
        input  din_valid, flush,
        output bfly_valid, shift_sel, twd_valid, twd_idx, out_valid, out_sop, out_eop,
        output frame_cnt, busy
    );
endinterface

// File: rtl/fft_sdf_stage_ctrl.sv
// Beat sequencer for one radix-2 SDF FFT stage: FILL/BFLY half-frame control, twiddle index,
// and a fixed-latency valid/sop/eop pipe that tracks butterfly+twiddle delay.
module fft_sdf_stage_ctrl #(
    parameter int unsigned HALF_BEATS = 16,
    parameter int unsigned LAT        = 5,
    parameter int unsigned FCNT_W     = 16
) (
    input logic                  clk,
    input logic                  rstn,
    fft_sdf_stage_ctrl_if.slave  bus
);
    localparam int unsigned CntW = $clog2(HALF_BEATS);

    typedef enum logic [1:0] {StIdle, StFill, StBfly} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [CntW-1:0]   twd_idx_q;
    logic [FCNT_W-1:0] frame_cnt_q;
    logic [LAT-1:0]    v_q, v_d;
    logic [LAT-1:0]    sop_q, sop_d;
    logic [LAT-1:0]    eop_q, eop_d;
    logic              last;
    logic              bfly_valid;

    assign last       = (cnt_q == CntW'(HALF_BEATS - 1));
    assign bfly_valid = bus.din_valid & (state_q == StBfly) & ~bus.flush;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (bus.din_valid) begin
            unique case (state_q)
                StIdle: begin
                    state_d = StFill;
                    cnt_d   = CntW'(1);
                end
                StFill: begin
                    state_d = last ? StBfly : StFill;
                    cnt_d   = last ? '0 : cnt_q + CntW'(1);
                end
                StBfly: begin
                    state_d = last ? StIdle : StBfly;
                    cnt_d   = last ? '0 : cnt_q + CntW'(1);
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Stage 0 of the pipe doubles as the twiddle-valid register.
    always_comb begin
        v_d      = '0;
        sop_d    = '0;
        eop_d    = '0;
        v_d[0]   = bfly_valid;
        sop_d[0] = bfly_valid & (cnt_q == '0);
        eop_d[0] = bfly_valid & last;
        for (int unsigned i = 1; i < LAT; i++) begin
            v_d[i]   = v_q[i-1];
            sop_d[i] = sop_q[i-1];
            eop_d[i] = eop_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            v_q         <= '0;
            sop_q       <= '0;
            eop_q       <= '0;
            twd_idx_q   <= '0;
            frame_cnt_q <= '0;
        end else begin
            // A frame already on the output wire counts even if flush hits the same cycle.
            if (v_q[LAT-1] & eop_q[LAT-1]) begin
                frame_cnt_q <= frame_cnt_q + FCNT_W'(1);
            end
            if (bus.flush) begin
                state_q <= StIdle;
                cnt_q   <= '0;
                v_q     <= '0;
                sop_q   <= '0;
                eop_q   <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                v_q     <= v_d;
                sop_q   <= sop_d;
                eop_q   <= eop_d;
                if (bfly_valid) begin
                    twd_idx_q <= cnt_q;
                end
            end
        end
    end

    assign bus.bfly_valid = bfly_valid;
    assign bus.shift_sel  = (state_q == StBfly);
    assign bus.twd_valid  = v_q[0];
    assign bus.twd_idx    = twd_idx_q;
    assign bus.out_valid  = v_q[LAT-1];
    assign bus.out_sop    = v_q[LAT-1] & sop_q[LAT-1];
    assign bus.out_eop    = v_q[LAT-1] & eop_q[LAT-1];
    assign bus.frame_cnt  = frame_cnt_q;
    assign bus.busy       = (state_q != StIdle) | (|v_q);
endmodule

// File: tb/tb_fft_sdf_stage_ctrl.sv
// Bench for fft_sdf_stage_ctrl: directed and random beat patterns checked each cycle against
// a frame-position model that schedules expected outputs by absolute cycle number.
module tb_fft_sdf_stage_ctrl;
    localparam int HB    = 16;
    localparam int LAT   = 5;
    localparam int FW    = 4;
    localparam int NCYC  = 4096;

    logic clk;
    logic rstn;

    fft_sdf_stage_ctrl_if #(.HALF_BEATS(HB), .FCNT_W(FW)) bus ();

    fft_sdf_stage_ctrl #(
        .HALF_BEATS (HB),
        .LAT        (LAT),
        .FCNT_W     (FW)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model: position within frame (0..2*HB-1) and outputs scheduled by cycle.
    int pos;
    int fc;
    int tidx;
    int busy_until;
    int cyc;
    bit ev   [NCYC];
    bit esop [NCYC];
    bit eeop [NCYC];
    bit etv  [NCYC];

    int n_ov;
    int n_eop;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic clr_future(input int c);
        for (int i = 1; i <= LAT; i++) begin
            ev[c+i]   = 1'b0;
            esop[c+i] = 1'b0;
            eeop[c+i] = 1'b0;
            etv[c+i]  = 1'b0;
        end
    endtask

    task automatic step(input logic dv, input logic fl, input logic rs);
        int k;
        bus.din_valid = dv;
        bus.flush     = fl;
        rstn          = rs;
        #1;
        if (cyc + LAT + 1 >= NCYC) begin
            failures++;
            $display("FAIL cycle_budget observed=%0d required<%0d", cyc, NCYC - LAT - 1);
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $fatal(1, "cycle budget exhausted");
        end
        chk("bfly_valid", 32'(bus.bfly_valid), 32'(dv && !fl && pos >= HB));
        chk("shift_sel",  32'(bus.shift_sel),  32'(pos >= HB));
        chk("twd_valid",  32'(bus.twd_valid),  32'(etv[cyc]));
        chk("twd_idx",    32'(bus.twd_idx),    32'(tidx));
        chk("out_valid",  32'(bus.out_valid),  32'(ev[cyc]));
        chk("out_sop",    32'(bus.out_sop),    32'(esop[cyc]));
        chk("out_eop",    32'(bus.out_eop),    32'(eeop[cyc]));
        chk("frame_cnt",  32'(bus.frame_cnt),  32'(fc));
        chk("busy",       32'(bus.busy),       32'(pos != 0 || cyc <= busy_until));
        if (bus.out_valid === 1'b1) n_ov++;
        if (bus.out_eop === 1'b1) n_eop++;
        @(posedge clk);
        if (!rs) begin
            pos        = 0;
            fc         = 0;
            tidx       = 0;
            busy_until = -1;
            clr_future(cyc);
        end else begin
            if (ev[cyc] && eeop[cyc]) fc = (fc + 1) % (1 << FW);
            if (fl) begin
                pos        = 0;
                busy_until = -1;
                clr_future(cyc);
            end else if (dv) begin
                if (pos >= HB) begin
                    k               = pos - HB;
                    etv[cyc+1]      = 1'b1;
                    tidx            = k;
                    ev[cyc+LAT]     = 1'b1;
                    esop[cyc+LAT]   = (k == 0);
                    eeop[cyc+LAT]   = (k == HB - 1);
                    busy_until      = cyc + LAT;
                end
                pos = (pos + 1) % (2 * HB);
            end
        end
        #1;
        cyc++;
    endtask

    task automatic beats(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        for (int i = 0; i < NCYC; i++) begin
            ev[i] = 1'b0; esop[i] = 1'b0; eeop[i] = 1'b0; etv[i] = 1'b0;
        end
        pos = 0; fc = 0; tidx = 0; busy_until = -1; cyc = 0;
        bus.din_valid = 1'b0;
        bus.flush     = 1'b0;
        rstn          = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Single frame from reset
        n_ov = 0; n_eop = 0;
        beats(32);
        idle(8);
        chk("frame1_ov_count", 32'(n_ov), 32'd16);
        chk("frame1_eop_count", 32'(n_eop), 32'd1);

        // Three back-to-back frames
        n_ov = 0; n_eop = 0;
        beats(96);
        idle(8);
        chk("cont_ov_count", 32'(n_ov), 32'd48);
        chk("cont_eop_count", 32'(n_eop), 32'd3);

        // Gapped frame: a bubble after every beat, long gap mid-BFLY
        n_ov = 0; n_eop = 0;
        for (int b = 0; b < 32; b++) begin
            step(1'b1, 1'b0, 1'b1);
            step(1'b0, 1'b0, 1'b1);
            if (b == 21) idle(10);
        end
        idle(8);
        chk("gap_ov_count", 32'(n_ov), 32'd16);
        chk("gap_eop_count", 32'(n_eop), 32'd1);

        // Flush arriving with BFLY beat 7, then a clean frame
        n_eop = 0;
        beats(HB + 7);
        step(1'b1, 1'b1, 1'b1);
        idle(3);
        beats(32);
        idle(8);
        chk("flush_eop_count", 32'(n_eop), 32'd1);

        // Reset pulse on FILL beat 9, then a normal frame
        n_ov = 0; n_eop = 0;
        beats(9);
        step(1'b1, 1'b0, 1'b0);
        beats(32);
        idle(8);
        chk("rst_ov_count", 32'(n_ov), 32'd16);
        chk("rst_eop_count", 32'(n_eop), 32'd1);

        // Random beats with rare flushes
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 3) != 0), ($urandom_range(0, 63) == 0), 1'b1);
        end
        step(1'b0, 1'b1, 1'b1);
        idle(8);

        // Sixteen frames: frame counter must pass through its wrap
        n_ov = 0; n_eop = 0;
        beats(32 * 16);
        idle(8);
        chk("wrap_ov_count", 32'(n_ov), 32'd256);
        chk("wrap_eop_count", 32'(n_eop), 32'd16);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
